// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate function for the truth-table checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    OpAnd  = 2'd0,
    OpOr   = 2'd1,
    OpXor  = 2'd2,
    OpNand = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } state_t;

  localparam int unsigned CntW = 4;

  function automatic logic gate_expect(op_t op, logic a, logic b);
    logic y;
    case (op)
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpNand:  y = ~(a & b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational golden model of the 2-input gate selected by op.
module gate_ref
  import gate_check_pkg::*;
(
  input  op_t  op,
  input  logic a,
  input  logic b,
  output logic y
);

  always_comb begin
    y = gate_expect(op, a, b);
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks all four {a,b} vectors through an external 2-input gate and reports
// whether its output matches the selected gate function.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       a,
  output logic       b,
  input  logic       o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx
);

  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  state_t          state_q;
  op_t             op_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic            exp_y;

  gate_ref u_gate_ref (
    .op (op_q),
    .a  (a),
    .b  (b),
    .y  (exp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAnd;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q     <= op_t'(op);
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= 2'd0;
            idx_q    <= 2'd0;
            busy     <= 1'b1;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          a       <= idx_q[1];
          b       <= idx_q[0];
          cnt_q   <= CntLoad;
          state_q <= StSettle;
        end
        StSettle: begin
          // Counter starts at SETTLE_CYCLES-1 so this state lasts SETTLE_CYCLES cycles.
          if (cnt_q == '0) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCheck: begin
          if (o != exp_y) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            fail_idx <= idx_q;
            state_q  <= StDone;
          end else if (idx_q == 2'd3) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b1;
            fail_idx <= 2'd0;
            state_q  <= StDone;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= StDrive;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: directed table, corner sequences and random runs.
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_w = 2'b00;
  logic [1:0] op0 = 2'd0, op4 = 2'd0;
  logic [3:0] tt0 = 4'h0, tt4 = 4'h0;
  logic [1:0] a_w, b_w, o_w, busy_w, done_w, pass_w;
  logic [1:0] fi0, fi4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // External gate under test modelled as a truth table indexed by {a,b}.
  assign o_w[0] = tt0[{a_w[0], b_w[0]}];
  assign o_w[1] = tt4[{a_w[1], b_w[1]}];

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start_w[0]),
    .op       (op0),
    .a        (a_w[0]),
    .b        (b_w[0]),
    .o        (o_w[0]),
    .busy     (busy_w[0]),
    .done     (done_w[0]),
    .pass     (pass_w[0]),
    .fail_idx (fi0)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_w[1]),
    .op       (op4),
    .a        (a_w[1]),
    .b        (b_w[1]),
    .o        (o_w[1]),
    .busy     (busy_w[1]),
    .done     (done_w[1]),
    .pass     (pass_w[1]),
    .fail_idx (fi4)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] tt;
    bit         exp_pass;
    logic [1:0] exp_idx;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_bit(input int op, input int i);
    int a = i / 2;
    int b = i % 2;
    case (op)
      0:       return a * b;
      1:       return a + b - a * b;
      2:       return (a + b) % 2;
      default: return 1 - a * b;
    endcase
  endfunction

  task automatic model(input int op, input logic [3:0] tt, input int s,
                       output bit mp, output logic [1:0] mi, output int ml);
    mp = 1'b1;
    mi = 2'd0;
    ml = 4 * (s + 2);
    for (int i = 0; i < 4; i++) begin
      if (int'(tt[i]) != ref_bit(op, i)) begin
        mp = 1'b0;
        mi = 2'(i);
        ml = (i + 1) * (s + 2);
        break;
      end
    end
  endtask

  task automatic check_zero(input int sel);
    logic [1:0] fi;
    fi = (sel == 0) ? fi0 : fi4;
    check($sformatf("rst_a%0d", sel), int'(a_w[sel]), 0);
    check($sformatf("rst_b%0d", sel), int'(b_w[sel]), 0);
    check($sformatf("rst_busy%0d", sel), int'(busy_w[sel]), 0);
    check($sformatf("rst_done%0d", sel), int'(done_w[sel]), 0);
    check($sformatf("rst_pass%0d", sel), int'(pass_w[sel]), 0);
    check($sformatf("rst_fidx%0d", sel), int'(fi), 0);
  endtask

  // One full run; returns observed results and the cycles from the accepting edge to done.
  task automatic run(input int sel, input logic [1:0] op_v, input logic [3:0] tt_v,
                     input bit noise, output bit gp, output logic [1:0] gi,
                     output int lat, output bit ok);
    int s = (sel == 0) ? 1 : 4;
    ok = 1'b0;
    gp = 1'b0;
    gi = 2'd0;
    lat = 0;
    @(negedge clk);
    if (sel == 0) begin op0 = op_v; tt0 = tt_v; end
    else begin op4 = op_v; tt4 = tt_v; end
    start_w[sel] = 1'b1;
    @(posedge clk);
    #1 start_w[sel] = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (busy_w[sel] && done_w[sel]) check("busy_and_done", 1, 0);
      if ((n - 1) % (s + 2) == 0 && busy_w[sel])
        check("ab_vector", int'({a_w[sel], b_w[sel]}), (n - 1) / (s + 2));
      if (done_w[sel]) begin
        start_w[sel] = 1'b0;
        gp = pass_w[sel];
        gi = (sel == 0) ? fi0 : fi4;
        lat = n;
        ok = 1'b1;
        break;
      end
      if (noise) begin
        start_w[sel] = 1'($urandom);
        if (sel == 0) op0 = 2'($urandom); else op4 = 2'($urandom);
      end
    end
    start_w[sel] = 1'b0;
    if (!ok) check("done_timeout", 0, 1);
    else check("ab_hold_done", int'({a_w[sel], b_w[sel]}), gp ? 3 : int'(gi));
  endtask

  vec_t       tbl[7];
  bit         gp, ok, mp;
  logic [1:0] gi, mi;
  int         lat, ml;

  initial begin
    tbl[0] = '{op: 2'd1, tt: 4'b1110, exp_pass: 1'b1, exp_idx: 2'd0, exp_lat: 12};
    tbl[1] = '{op: 2'd0, tt: 4'b1110, exp_pass: 1'b0, exp_idx: 2'd1, exp_lat: 6};
    tbl[2] = '{op: 2'd3, tt: 4'b0000, exp_pass: 1'b0, exp_idx: 2'd0, exp_lat: 3};
    tbl[3] = '{op: 2'd2, tt: 4'b0110, exp_pass: 1'b1, exp_idx: 2'd0, exp_lat: 12};
    tbl[4] = '{op: 2'd0, tt: 4'b1000, exp_pass: 1'b1, exp_idx: 2'd0, exp_lat: 12};
    tbl[5] = '{op: 2'd3, tt: 4'b0111, exp_pass: 1'b1, exp_idx: 2'd0, exp_lat: 12};
    tbl[6] = '{op: 2'd2, tt: 4'b1110, exp_pass: 1'b0, exp_idx: 2'd3, exp_lat: 12};

    repeat (3) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(0, tbl[i].op, tbl[i].tt, 1'b0, gp, gi, lat, ok);
      if (ok) begin
        check($sformatf("tbl%0d_pass", i), int'(gp), int'(tbl[i].exp_pass));
        check($sformatf("tbl%0d_idx", i), int'(gi), int'(tbl[i].exp_idx));
        check($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      end
    end

    // Long settle with mid-run start pulses and op changes.
    run(1, 2'd2, 4'b0110, 1'b1, gp, gi, lat, ok);
    if (ok) begin
      check("s4_xor_pass", int'(gp), 1);
      check("s4_xor_idx", int'(gi), 0);
      check("s4_xor_lat", lat, 24);
    end

    // Reset during settle of vector 2.
    @(negedge clk);
    op0 = 2'd1;
    tt0 = 4'b1110;
    start_w[0] = 1'b1;
    @(posedge clk);
    #1 start_w[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_ab", int'({a_w[0], b_w[0]}), 2);
    check("pre_rst_busy", int'(busy_w[0]), 1);
    rst = 1'b1;
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    start_w[0] = 1'b0;
    run(0, 2'd1, 4'b1110, 1'b0, gp, gi, lat, ok);
    if (ok) begin
      check("post_rst_pass", int'(gp), 1);
      check("post_rst_lat", lat, 12);
    end

    // Random gates against the reference model, both settle settings.
    for (int r = 0; r < 30; r++) begin
      int sel = r % 2;
      logic [1:0] rop = 2'($urandom);
      logic [3:0] rtt = 4'($urandom);
      model(int'(rop), rtt, (sel == 0) ? 1 : 4, mp, mi, ml);
      run(sel, rop, rtt, 1'($urandom_range(0, 1)), gp, gi, lat, ok);
      if (ok) begin
        check($sformatf("rnd%0d_pass", r), int'(gp), int'(mp));
        check($sformatf("rnd%0d_idx", r), int'(gi), int'(mi));
        check($sformatf("rnd%0d_lat", r), lat, ml);
      end
    end

    // Start held high: one-cycle done pulse every 13 cycles.
    @(negedge clk);
    op0 = 2'd1;
    tt0 = 4'b1110;
    start_w[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("held_done_n%0d", n), int'(done_w[0]), (n % 13 == 12) ? 1 : 0);
      if (done_w[0]) check($sformatf("held_pass_n%0d", n), int'(pass_w[0]), 1);
    end
    start_w[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles between driving a/b and sampling o (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request for a full truth-table run.
REQ-005 SHALL have port op, input, 2, gate under test (0 AND, 1 OR, 2 XOR, 3 NAND); sampled only when start is accepted.
REQ-006 SHALL have port a, output, 1, first operand driven to the 2-input gate under test.
REQ-007 SHALL have port b, output, 1, second operand driven to the gate under test.
REQ-008 SHALL have port o, input, 1, result returned by the gate under test.
REQ-009 SHALL have port busy, output, 1, high while a run is in progress.
REQ-010 SHALL have port done, output, 1, high while results of the last run are valid.
REQ-011 SHALL have port pass, output, 1, all four vectors matched; meaningful only when done=1.
REQ-012 SHALL have port fail_idx, output, 2, vector index {a,b} of the first mismatch; 0 when pass=1.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in any other state is ignored, with no effect on op or progress.
REQ-015 On acceptance SHALL latch op, clear done, pass and fail_idx, set idx=0, set busy=1, and go to DRIVE.
REQ-016 SHALL apply vectors in order idx 0,1,2,3 with a=idx[1] and b=idx[0]; a/b are registered outputs.
REQ-017 DRIVE SHALL update a/b from idx, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE next cycle.
REQ-018 SETTLE SHALL hold a/b, count down to 0, then go to CHECK; it lasts exactly SETTLE_CYCLES cycles.
REQ-019 CHECK SHALL compare o against the expected value from the latched op and current a/b.
REQ-020 On mismatch in CHECK: go to DONE with pass=0, fail_idx=idx; remaining vectors are skipped.
REQ-021 On match in CHECK with idx<3: increment idx and go to DRIVE; with idx=3: go to DONE with pass=1, fail_idx=0.
REQ-022 DONE SHALL hold done=1, busy=0, pass/fail_idx stable, and a/b at their last values until start is accepted or rst is asserted.
REQ-023 Latency for an all-pass run SHALL be exactly 4*(2+SETTLE_CYCLES) cycles from the edge that accepts start to the first cycle with done=1 (12 for default).
REQ-024 busy and done SHALL never be high together; exactly one of busy/done/idle-state holds at any time.
REQ-025 start held high continuously SHALL restart a new run on the cycle after each entry into DONE, with done high for exactly one cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE with a=0, b=0, busy=0, done=0, pass=0, fail_idx=0, idx=0, and latched op=0, in any state including mid-run.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Shared package gate_check_pkg SHALL hold the op_t enum (AND/OR/XOR/NAND), the state_t enum, and the expected-value function gate_expect(op,a,b).
REQ-029 One combinational sub-module, gate_ref (inputs op,a,b; output y), SHALL compute the expected value via gate_expect; the checker instantiates it once.

Verification
REQ-030 Loop to the mux-based OR gate (or_gate_using_mux), op=1, start pulse -> done after 12 cycles, pass=1, fail_idx=0; a/b sequence 00,01,10,11.
REQ-031 Same loop, op=0 (AND) -> first mismatch at vector 01: done=1, pass=0, fail_idx=1 after 2*3=6 cycles.
REQ-032 Behavioural stuck-at-0 gate, op=3 (NAND) -> pass=0, fail_idx=0 after 3 cycles.
REQ-033 SETTLE_CYCLES=4, correct XOR model, op=2 -> pass=1 after 24 cycles; start pulses mid-run are ignored, and op changes mid-run do not alter the result.
REQ-034 rst asserted during SETTLE of vector 2 -> next cycle all outputs are 0 and the FSM is in IDLE; a subsequent start completes normally.
REQ-035 start held high with correct OR gate -> done pulses one cycle every 13 cycles, and pass=1 on each pulse.
